// File: rtl/clause_queue_if.sv
// Clause queue bus: distributor push lane, engine pop handshake and status.
// The slave modport is the queue itself; the master modport is whoever drives it.
interface clause_queue_if #(
    parameter int VAR_W   = 11,
    parameter int CLA_LEN = 3,
    parameter int DEPTH   = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [VAR_W*CLA_LEN-1:0] clause_in;
    logic                     grant_in;
    logic                     full_out;
    logic                     flush_in;
    logic [VAR_W*CLA_LEN-1:0] clause_out;
    logic                     valid_out;
    logic                     ready_in;
    logic [CW-1:0]            count_out;
    logic                     empty_out;
    logic                     overflow_out;

    modport slave (
        input  clause_in, grant_in, flush_in, ready_in,
        output full_out, clause_out, valid_out, count_out, empty_out, overflow_out
    );

    modport master (
        output clause_in, grant_in, flush_in, ready_in,
        input  full_out, clause_out, valid_out, count_out, empty_out, overflow_out
    );
endinterface

// File: rtl/clause_queue.sv
// Per-engine receive-side clause FIFO with early full (skid-absorbing) back-pressure,
// sticky overflow flag and a synchronous flush.
module clause_queue #(
    parameter int VAR_W   = 11,
    parameter int CLA_LEN = 3,
    parameter int DEPTH   = 16,
    parameter int SKID    = 2
) (
    input  logic         clock,
    input  logic         reset,
    clause_queue_if.slave bus
);
    localparam int W  = VAR_W * CLA_LEN;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full_q;
    logic          overflow_q;
    logic          valid;
    logic          push;
    logic          pop;
    logic          drop;

    assign valid = (count != '0);
    assign pop   = valid && bus.ready_in && !bus.flush_in;
    assign push  = bus.grant_in && ((count < CW'(DEPTH)) || pop) && !bus.flush_in;
    // A grant is lost only when every slot is occupied and nothing leaves this cycle.
    assign drop  = bus.grant_in && !bus.flush_in && (count == CW'(DEPTH)) && !pop;

    always_comb begin
        count_next = count;
        if (bus.flush_in) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.flush_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count  <= count_next;
            // Raised SKID entries early so grants already in flight still find room.
            full_q <= (count_next >= CW'(DEPTH - SKID));
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.clause_in;
    end

    assign bus.valid_out    = valid;
    assign bus.clause_out   = valid ? mem[rd_ptr] : '0;
    assign bus.count_out    = count;
    assign bus.empty_out    = !valid;
    assign bus.full_out     = full_q;
    assign bus.overflow_out = overflow_q;
endmodule

// File: tb/tb_clause_queue.sv
// Directed bench for clause_queue: reset, threshold, overflow, full push/pop, flush,
// wrap-around ordering and mid-operation reset.
module tb_clause_queue;
    localparam int VAR_W   = 11;
    localparam int CLA_LEN = 3;
    localparam int DEPTH   = 16;
    localparam int SKID    = 2;
    localparam int W       = VAR_W * CLA_LEN;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    clause_queue_if #(.VAR_W(VAR_W), .CLA_LEN(CLA_LEN), .DEPTH(DEPTH)) bus ();

    clause_queue #(.VAR_W(VAR_W), .CLA_LEN(CLA_LEN), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [W-1:0] mk(input int i);
        return {11'(i), 11'(i + 100), 11'(i + 200)};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are held for exactly one rising edge, then returned to idle 1ns after it.
    task automatic apply_stimulus(input logic g, input logic [W-1:0] c, input logic r, input logic f);
        bus.grant_in  = g;
        bus.clause_in = c;
        bus.ready_in  = r;
        bus.flush_in  = f;
        @(posedge clock);
        #1;
        bus.grant_in  = 1'b0;
        bus.ready_in  = 1'b0;
        bus.flush_in  = 1'b0;
    endtask

    initial begin
        logic [W-1:0] model[$];
        int pushed;
        int cyc;
        logic g;
        logic r;

        checks = 0;
        failures = 0;
        bus.grant_in = 1'b0;
        bus.ready_in = 1'b0;
        bus.flush_in = 1'b0;
        bus.clause_in = '0;
        reset = 1'b0;

        repeat (3) begin
            @(posedge clock);
            #1;
            check_output("rst_valid", 64'(bus.valid_out), 64'd0);
            check_output("rst_empty", 64'(bus.empty_out), 64'd1);
            check_output("rst_count", 64'(bus.count_out), 64'd0);
            check_output("rst_full", 64'(bus.full_out), 64'd0);
            check_output("rst_ovf", 64'(bus.overflow_out), 64'd0);
            check_output("rst_clause", 64'(bus.clause_out), 64'd0);
        end
        reset = 1'b1;

        apply_stimulus(1'b1, 33'h0_0400_0801, 1'b0, 1'b0);
        check_output("single_valid", 64'(bus.valid_out), 64'd1);
        check_output("single_clause", 64'(bus.clause_out), 64'h0_0400_0801);
        check_output("single_count", 64'(bus.count_out), 64'd1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("single_pop_valid", 64'(bus.valid_out), 64'd0);
        check_output("single_pop_empty", 64'(bus.empty_out), 64'd1);

        for (int i = 1; i <= 14; i++) begin
            apply_stimulus(1'b1, mk(i), 1'b0, 1'b0);
            if (i == 13) check_output("full_at13", 64'(bus.full_out), 64'd0);
        end
        check_output("full_at14", 64'(bus.full_out), 64'd1);
        check_output("count_at14", 64'(bus.count_out), 64'd14);
        apply_stimulus(1'b1, mk(15), 1'b0, 1'b0);
        apply_stimulus(1'b1, mk(16), 1'b0, 1'b0);
        check_output("count_at16", 64'(bus.count_out), 64'd16);
        check_output("ovf_at16", 64'(bus.overflow_out), 64'd0);

        apply_stimulus(1'b1, mk(99), 1'b0, 1'b0);
        check_output("ovf_count", 64'(bus.count_out), 64'd16);
        check_output("ovf_set", 64'(bus.overflow_out), 64'd1);
        check_output("ovf_head", 64'(bus.clause_out), 64'(mk(1)));

        apply_stimulus(1'b1, mk(50), 1'b1, 1'b0);
        check_output("pp_count", 64'(bus.count_out), 64'd16);
        check_output("pp_head", 64'(bus.clause_out), 64'(mk(2)));
        for (int i = 2; i <= 17; i++) begin
            check_output("drain", 64'(bus.clause_out), 64'((i == 17) ? mk(50) : mk(i)));
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        end
        check_output("drain_empty", 64'(bus.empty_out), 64'd1);
        check_output("drain_full", 64'(bus.full_out), 64'd0);

        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, mk(200 + i), 1'b0, 1'b0);
        check_output("pre_flush_count", 64'(bus.count_out), 64'd5);
        apply_stimulus(1'b1, mk(300), 1'b1, 1'b1);
        check_output("flush_count", 64'(bus.count_out), 64'd0);
        check_output("flush_valid", 64'(bus.valid_out), 64'd0);
        check_output("flush_full", 64'(bus.full_out), 64'd0);
        check_output("flush_clause", 64'(bus.clause_out), 64'd0);
        check_output("flush_ovf", 64'(bus.overflow_out), 64'd1);
        apply_stimulus(1'b1, mk(301), 1'b0, 1'b0);
        check_output("post_flush_head", 64'(bus.clause_out), 64'(mk(301)));
        check_output("post_flush_count", 64'(bus.count_out), 64'd1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        // Scoreboarded wrap-around: pointers cross the DEPTH boundary several times.
        pushed = 0;
        cyc = 0;
        while ((pushed < 40 || model.size() != 0) && cyc < 2000) begin
            g = (pushed < 40) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 1) == 1);
            check_output("wrap_valid", 64'(bus.valid_out), 64'(model.size() != 0));
            if (r && model.size() != 0) begin
                check_output("wrap_order", 64'(bus.clause_out), 64'(model[0]));
                void'(model.pop_front());
                if (g) begin model.push_back(mk(400 + pushed)); pushed++; end
            end else if (g && model.size() < DEPTH) begin
                model.push_back(mk(400 + pushed));
                pushed++;
            end
            apply_stimulus(g, mk(400 + pushed - ((g && (model.size() != 0)) ? 1 : 0)), r, 1'b0);
            check_output("wrap_count", 64'(bus.count_out), 64'(model.size()));
            cyc++;
        end
        check_output("wrap_done", 64'(cyc < 2000), 64'd1);

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, mk(500 + i), 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_output("midrst_count", 64'(bus.count_out), 64'd0);
        check_output("midrst_valid", 64'(bus.valid_out), 64'd0);
        check_output("midrst_ovf", 64'(bus.overflow_out), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        apply_stimulus(1'b1, mk(600), 1'b0, 1'b0);
        check_output("rel_count", 64'(bus.count_out), 64'd1);
        check_output("rel_head", 64'(bus.clause_out), 64'(mk(600)));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
